// File: rtl/tty_rx_checker_pkg.sv
// Shared constants, state encodings and helpers for the TTY receive checker.
package tty_rx_checker_pkg;

  localparam logic [6:0]  CHR_FIRST    = 7'h20;
  localparam logic [6:0]  CHR_LAST     = 7'h7E;
  localparam logic [6:0]  CHR_CR       = 7'h0D;
  localparam logic [6:0]  CHR_LF       = 7'h0A;
  localparam int unsigned TTY_LINE_LEN = 80;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

  typedef enum logic [2:0] {
    PH_HUNT    = 3'd0,
    PH_FIRST   = 3'd1,
    PH_CHARS   = 3'd2,
    PH_WANT_CR = 3'd3,
    PH_WANT_LF = 3'd4
  } chk_phase_e;

  // Next character of the printable pattern, wrapping 0x7E back to 0x20.
  function automatic logic [6:0] next_char(input logic [6:0] c);
    return (c == CHR_LAST) ? CHR_FIRST : c + 7'd1;
  endfunction

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 receiver: 2-flop synchroniser, falling-edge start detect, mid-bit sampling.
module uart_rx_core
  import tty_rx_checker_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 10417
) (
  input  logic       clk100,
  input  logic       resetn,
  input  logic       rx,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_LOAD = CW'(CLKS_PER_BIT - 1);

  logic [1:0]    r_sync;
  logic [1:0]    r_warm;
  logic          r_prev;
  rx_state_e     r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;
  logic [7:0]    r_byte;
  logic          r_byte_valid;
  logic          r_frame_err;

  logic w_rx;
  logic w_fall;
  logic w_expire;

  assign w_rx     = r_sync[1];
  // r_prev stays low until the synchroniser holds real line samples, so a line
  // already low when reset is released never looks like a start edge.
  assign w_fall   = r_prev & ~w_rx;
  assign w_expire = (r_cnt == '0);

  always_ff @(posedge clk100 or negedge resetn) begin
    if (!resetn) begin
      r_sync       <= 2'b11;
      r_warm       <= 2'd0;
      r_prev       <= 1'b0;
      r_state      <= RX_IDLE;
      r_cnt        <= '0;
      r_bit        <= 3'd0;
      r_shift      <= 8'd0;
      r_byte       <= 8'd0;
      r_byte_valid <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_sync       <= {r_sync[0], rx};
      r_byte_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      if (r_warm != 2'd2) r_warm <= r_warm + 2'd1;
      r_prev <= (r_warm == 2'd2) ? w_rx : 1'b0;

      case (r_state)
        RX_IDLE: begin
          if (w_fall) begin
            r_cnt   <= HALF_LOAD;
            r_state <= RX_START;
          end
        end
        RX_START: begin
          if (!w_expire) begin
            r_cnt <= r_cnt - CW'(1);
          end else if (!w_rx) begin
            r_cnt   <= FULL_LOAD;
            r_bit   <= 3'd0;
            r_state <= RX_DATA;
          end else begin
            r_state <= RX_IDLE;
          end
        end
        RX_DATA: begin
          if (!w_expire) begin
            r_cnt <= r_cnt - CW'(1);
          end else begin
            r_shift <= {w_rx, r_shift[7:1]};
            r_cnt   <= FULL_LOAD;
            if (r_bit == 3'd7) r_state <= RX_STOP;
            else               r_bit   <= r_bit + 3'd1;
          end
        end
        RX_STOP: begin
          if (!w_expire) begin
            r_cnt <= r_cnt - CW'(1);
          end else begin
            if (w_rx) begin
              r_byte       <= r_shift;
              r_byte_valid <= 1'b1;
            end else begin
              r_frame_err  <= 1'b1;
            end
            r_state <= RX_IDLE;
          end
        end
        default: r_state <= RX_IDLE;
      endcase
    end
  end

  assign rx_byte    = r_byte;
  assign byte_valid = r_byte_valid;
  assign frame_err  = r_frame_err;

endmodule

// File: rtl/tty_rx_checker.sv
// Checks the received byte stream against the repeating printable-ASCII line pattern.
module tty_rx_checker
  import tty_rx_checker_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 10417,
  parameter int unsigned LINE_LEN     = TTY_LINE_LEN
) (
  input  logic        clk100,
  input  logic        resetn,
  input  logic        rx,
  output logic [11:0] rx_char,
  output logic        rx_valid,
  output logic        locked,
  output logic [11:0] err_cnt,
  output logic [11:0] line_cnt,
  output logic        frame_err
);

  localparam logic [6:0] LINE_LEN7 = 7'(LINE_LEN);

  logic [7:0]  w_byte;
  logic        w_byte_valid;
  logic        w_frame_err;
  logic        w_is_lf;
  logic        w_is_cr;
  logic        w_is_print;
  logic        w_exp_hit;
  logic        w_mismatch;
  logic [6:0]  w_col_next;
  logic [11:0] w_err_inc;

  chk_phase_e  r_phase;
  logic [6:0]  r_exp_char;
  logic [6:0]  r_col;
  logic [11:0] r_rx_char;
  logic        r_rx_valid;
  logic        r_locked;
  logic [11:0] r_err_cnt;
  logic [11:0] r_line_cnt;
  logic        r_frame_err;

  uart_rx_core #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_core (
    .clk100     (clk100),
    .resetn     (resetn),
    .rx         (rx),
    .rx_byte    (w_byte),
    .byte_valid (w_byte_valid),
    .frame_err  (w_frame_err)
  );

  assign w_is_lf    = (w_byte == {1'b0, CHR_LF});
  assign w_is_cr    = (w_byte == {1'b0, CHR_CR});
  assign w_is_print = (w_byte >= {1'b0, CHR_FIRST}) && (w_byte <= {1'b0, CHR_LAST});
  assign w_exp_hit  = (w_byte == {1'b0, r_exp_char});
  assign w_col_next = r_col + 7'd1;
  assign w_err_inc  = (r_err_cnt == 12'hFFF) ? r_err_cnt : r_err_cnt + 12'd1;
  assign w_mismatch = ((r_phase == PH_CHARS)   && !w_exp_hit) ||
                      ((r_phase == PH_WANT_CR) && !w_is_cr)   ||
                      ((r_phase == PH_WANT_LF) && !w_is_lf);

  always_ff @(posedge clk100 or negedge resetn) begin
    if (!resetn) begin
      r_phase     <= PH_HUNT;
      r_exp_char  <= 7'd0;
      r_col       <= 7'd0;
      r_rx_char   <= 12'd0;
      r_rx_valid  <= 1'b0;
      r_locked    <= 1'b0;
      r_err_cnt   <= 12'd0;
      r_line_cnt  <= 12'd0;
      r_frame_err <= 1'b0;
    end else begin
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
      if (w_byte_valid) begin
        r_rx_char  <= {4'd0, w_byte};
        r_rx_valid <= 1'b1;
        if (w_mismatch) begin
          // A mismatching LF can still serve as the start of acquisition.
          r_err_cnt <= w_err_inc;
          r_locked  <= 1'b0;
          r_phase   <= w_is_lf ? PH_FIRST : PH_HUNT;
        end else begin
          case (r_phase)
            PH_HUNT: if (w_is_lf) r_phase <= PH_FIRST;
            PH_FIRST: begin
              if (w_is_print) begin
                r_exp_char <= next_char(w_byte[6:0]);
                r_col      <= 7'd1;
                r_locked   <= 1'b1;
                r_phase    <= (LINE_LEN7 == 7'd1) ? PH_WANT_CR : PH_CHARS;
              end else begin
                r_phase    <= PH_HUNT;
              end
            end
            PH_CHARS: begin
              r_exp_char <= next_char(r_exp_char);
              r_col      <= w_col_next;
              if (w_col_next == LINE_LEN7) r_phase <= PH_WANT_CR;
            end
            PH_WANT_CR: r_phase <= PH_WANT_LF;
            PH_WANT_LF: begin
              r_line_cnt <= r_line_cnt + 12'd1;
              r_col      <= 7'd0;
              r_phase    <= PH_CHARS;
            end
            default: r_phase <= PH_HUNT;
          endcase
        end
      end else if (w_frame_err) begin
        r_frame_err <= 1'b1;
        r_err_cnt   <= w_err_inc;
        if (r_locked) begin
          r_locked <= 1'b0;
          r_phase  <= PH_HUNT;
        end
      end
    end
  end

  assign rx_char   = r_rx_char;
  assign rx_valid  = r_rx_valid;
  assign locked    = r_locked;
  assign err_cnt   = r_err_cnt;
  assign line_cnt  = r_line_cnt;
  assign frame_err = r_frame_err;

endmodule

// File: tb/tb_tty_rx_checker.sv
// Directed bench for tty_rx_checker: vector table of serial frames plus corner-case sequences.
module tb_tty_rx_checker;

  localparam int unsigned CPB = 16;
  localparam int unsigned LL  = 4;

  logic        clk100;
  logic        resetn;
  logic        rx;
  logic [11:0] rx_char;
  logic        rx_valid;
  logic        locked;
  logic [11:0] err_cnt;
  logic [11:0] line_cnt;
  logic        frame_err;

  int n_checks = 0;
  int n_errors = 0;
  int n_valid  = 0;
  int n_ferr   = 0;
  int n_both   = 0;

  typedef struct {
    logic [7:0]  data;
    bit          stop_ok;
    int unsigned gap;
    bit          exp_lock;
    logic [11:0] exp_err;
    logic [11:0] exp_line;
  } vec_t;

  vec_t vecs[$];

  tty_rx_checker #(.CLKS_PER_BIT(CPB), .LINE_LEN(LL)) dut (
    .clk100    (clk100),
    .resetn    (resetn),
    .rx        (rx),
    .rx_char   (rx_char),
    .rx_valid  (rx_valid),
    .locked    (locked),
    .err_cnt   (err_cnt),
    .line_cnt  (line_cnt),
    .frame_err (frame_err)
  );

  initial clk100 = 1'b0;
  always #5 clk100 = ~clk100;

  // Pulse monitor, sampled on the inactive edge.
  always @(negedge clk100) begin
    if (rx_valid)              n_valid <= n_valid + 1;
    if (frame_err)             n_ferr  <= n_ferr + 1;
    if (rx_valid && frame_err) n_both  <= n_both + 1;
  end

  task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drives one 8N1 frame starting at a falling clock edge, then gap idle bit-times.
  task automatic send_frame(input logic [7:0] d, input bit stop_ok, input int unsigned gap);
    rx = 1'b0;
    repeat (CPB) @(negedge clk100);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (CPB) @(negedge clk100);
    end
    rx = stop_ok;
    repeat (CPB) @(negedge clk100);
    rx = 1'b1;
    repeat (gap * CPB) @(negedge clk100);
  endtask

  task automatic add(input logic [7:0] d, input bit ok, input int unsigned gap,
                     input bit lk, input logic [11:0] e, input logic [11:0] n);
    vec_t v;
    v.data = d; v.stop_ok = ok; v.gap = gap; v.exp_lock = lk; v.exp_err = e; v.exp_line = n;
    vecs.push_back(v);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int bv;
    int bf;
    bv = n_valid;
    bf = n_ferr;
    send_frame(v.data, v.stop_ok, v.gap);
    chk({tag, " rx_valid pulses"},  12'(n_valid - bv), v.stop_ok ? 12'd1 : 12'd0);
    chk({tag, " frame_err pulses"}, 12'(n_ferr - bf),  v.stop_ok ? 12'd0 : 12'd1);
    if (v.stop_ok) chk({tag, " rx_char"}, rx_char, {4'h0, v.data});
    chk({tag, " locked"},   {11'd0, locked}, {11'd0, v.exp_lock});
    chk({tag, " err_cnt"},  err_cnt,  v.exp_err);
    chk({tag, " line_cnt"}, line_cnt, v.exp_line);
  endtask

  initial begin
    vec_t v;
    int bv;
    int bf;

    // data, stop_ok, gap, locked, err_cnt, line_cnt after the byte
    add(8'h41, 1, 0, 0, 12'd0, 12'd0);
    add(8'h0A, 1, 0, 0, 12'd0, 12'd0);
    add(8'h20, 1, 0, 1, 12'd0, 12'd0);
    add(8'h21, 1, 0, 1, 12'd0, 12'd0);
    add(8'h22, 1, 0, 1, 12'd0, 12'd0);
    add(8'h23, 1, 0, 1, 12'd0, 12'd0);
    add(8'h0D, 1, 0, 1, 12'd0, 12'd0);
    add(8'h0A, 1, 0, 1, 12'd0, 12'd1);
    add(8'h24, 1, 0, 1, 12'd0, 12'd1);
    add(8'h25, 1, 0, 1, 12'd0, 12'd1);
    add(8'h26, 1, 0, 1, 12'd0, 12'd1);
    add(8'h27, 1, 1, 1, 12'd0, 12'd1);
    add(8'h0D, 1, 0, 1, 12'd0, 12'd1);
    add(8'h0A, 1, 0, 1, 12'd0, 12'd2);
    add(8'h28, 1, 0, 1, 12'd0, 12'd2);
    add(8'h29, 1, 0, 1, 12'd0, 12'd2);
    add(8'h2A, 1, 0, 1, 12'd0, 12'd2);
    add(8'h2B, 1, 0, 1, 12'd0, 12'd2);
    add(8'h0D, 1, 0, 1, 12'd0, 12'd2);
    add(8'h0A, 1, 0, 1, 12'd0, 12'd3);
    add(8'h2C, 1, 0, 1, 12'd0, 12'd3);
    add(8'h2D, 1, 0, 1, 12'd0, 12'd3);
    add(8'h2E, 1, 0, 1, 12'd0, 12'd3);
    add(8'h2F, 1, 0, 1, 12'd0, 12'd3);
    add(8'h0D, 1, 0, 1, 12'd0, 12'd3);
    add(8'h0A, 1, 0, 1, 12'd0, 12'd4);
    add(8'h31, 1, 0, 0, 12'd1, 12'd4);
    add(8'h0A, 1, 0, 0, 12'd1, 12'd4);
    add(8'h7B, 1, 0, 1, 12'd1, 12'd4);
    add(8'h7C, 1, 0, 1, 12'd1, 12'd4);
    add(8'h7D, 1, 0, 1, 12'd1, 12'd4);
    add(8'h7E, 1, 0, 1, 12'd1, 12'd4);
    add(8'h0D, 1, 0, 1, 12'd1, 12'd4);
    add(8'h0A, 1, 0, 1, 12'd1, 12'd5);
    add(8'h20, 1, 0, 1, 12'd1, 12'd5);
    add(8'h21, 1, 0, 1, 12'd1, 12'd5);
    add(8'h0A, 1, 0, 0, 12'd2, 12'd5);
    add(8'h40, 1, 0, 1, 12'd2, 12'd5);
    add(8'h41, 1, 0, 1, 12'd2, 12'd5);
    add(8'h42, 0, 1, 0, 12'd3, 12'd5);

    // Reset held while rx toggles: everything stays at zero.
    resetn = 1'b0;
    rx     = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk100);
      rx = ~rx;
    end
    chk("reset rx_char",   rx_char,            12'd0);
    chk("reset rx_valid",  {11'd0, rx_valid},  12'd0);
    chk("reset locked",    {11'd0, locked},    12'd0);
    chk("reset err_cnt",   err_cnt,            12'd0);
    chk("reset line_cnt",  line_cnt,           12'd0);
    chk("reset frame_err", {11'd0, frame_err}, 12'd0);
    rx = 1'b1;
    repeat (4) @(negedge clk100);
    resetn = 1'b1;
    repeat (6) @(negedge clk100);

    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], $sformatf("v%0d", i));

    // One-cycle low glitch on idle line produces no output.
    bv = n_valid;
    bf = n_ferr;
    rx = 1'b0;
    @(negedge clk100);
    rx = 1'b1;
    repeat (3 * CPB) @(negedge clk100);
    chk("glitch rx_valid",  12'(n_valid - bv), 12'd0);
    chk("glitch frame_err", 12'(n_ferr - bf),  12'd0);
    chk("glitch err_cnt",   err_cnt,           12'd3);

    v = '{data: 8'h0A, stop_ok: 1, gap: 0, exp_lock: 0, exp_err: 12'd3, exp_line: 12'd5};
    run_vec(v, "relock lf");
    v = '{data: 8'h50, stop_ok: 1, gap: 0, exp_lock: 1, exp_err: 12'd3, exp_line: 12'd5};
    run_vec(v, "relock chr");

    // Preload the error counter near full scale, then drive it into saturation.
    force dut.r_err_cnt = 12'hFFD;
    @(negedge clk100);
    release dut.r_err_cnt;
    @(negedge clk100);
    v = '{data: 8'h51, stop_ok: 0, gap: 1, exp_lock: 0, exp_err: 12'hFFE, exp_line: 12'd5};
    run_vec(v, "sat1");
    v.exp_err = 12'hFFF;
    run_vec(v, "sat2");
    run_vec(v, "sat3");
    run_vec(v, "sat4");

    // Reset asserted mid-frame clears counters asynchronously.
    rx = 1'b0;
    repeat (40) @(negedge clk100);
    resetn = 1'b0;
    #1;
    chk("midreset err_cnt",  err_cnt,         12'd0);
    chk("midreset line_cnt", line_cnt,        12'd0);
    chk("midreset locked",   {11'd0, locked}, 12'd0);
    chk("midreset rx_char",  rx_char,         12'd0);
    repeat (3) @(negedge clk100);
    resetn = 1'b1;
    // Line still low after release must not be taken as a start edge.
    bv = n_valid;
    bf = n_ferr;
    repeat (30) @(negedge clk100);
    rx = 1'b1;
    repeat (2 * CPB) @(negedge clk100);
    chk("postreset rx_valid",  12'(n_valid - bv), 12'd0);
    chk("postreset frame_err", 12'(n_ferr - bf),  12'd0);
    v = '{data: 8'h55, stop_ok: 1, gap: 1, exp_lock: 0, exp_err: 12'd0, exp_line: 12'd0};
    run_vec(v, "postreset byte");

    chk("valid and frame_err together", 12'(n_both), 12'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
